// File: rtl/mysystem_pio_edge_if.sv
// Slave bus between a host and the PIO edge-capture block.
interface mysystem_pio_edge_if;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;

    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/mysystem_pio_edge.sv
// Parallel I/O port: output data/direction registers, synchronised inputs
// with per-bit sticky edge capture, a masked level interrupt, and an
// address-selected registered read port.
module mysystem_pio_edge #(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    mysystem_pio_edge_if.slave      bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic [WIDTH-1:0]        out_port,
    output logic [WIDTH-1:0]        out_en,
    output logic                    irq
);
    localparam int unsigned DW = 32;

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_DIR   = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;
    localparam logic [2:0] ADDR_SET   = 3'd4;
    localparam logic [2:0] ADDR_CLR   = 3'd5;

    logic [WIDTH-1:0] sync1_q, sync2_q, sync3_q;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] direction_q, direction_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             irq_q, irq_d;
    logic [DW-1:0]    readdata_q, readdata_d;

    logic [WIDTH-1:0] edges_c;
    logic [WIDTH-1:0] wdata_c;
    logic             wr_en_c;
    logic             unused_wdata_c;

    assign wr_en_c        = bus.chipselect & ~bus.write_n;
    assign wdata_c        = bus.writedata[WIDTH-1:0];
    assign unused_wdata_c = ^bus.writedata;

    // Input synchroniser plus one extra stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Per-bit edge detect, polarity chosen at elaboration.
    always_comb begin
        edges_c = '0;
        case (EDGE_TYPE)
            0:       edges_c = sync2_q & ~sync3_q;
            1:       edges_c = ~sync2_q & sync3_q;
            default: edges_c = sync2_q ^ sync3_q;
        endcase
    end

    // Register writes; a newly detected edge overrides a same-cycle clear.
    always_comb begin
        data_out_d  = data_out_q;
        direction_d = direction_q;
        irqmask_d   = irqmask_q;
        edgecap_d   = edgecap_q | edges_c;
        if (wr_en_c) begin
            case (bus.address)
                ADDR_DATA: data_out_d  = wdata_c;
                ADDR_DIR:  direction_d = wdata_c;
                ADDR_MASK: irqmask_d   = wdata_c;
                ADDR_EDGE: edgecap_d   = (edgecap_q & ~wdata_c) | edges_c;
                ADDR_SET:  data_out_d  = data_out_q | wdata_c;
                ADDR_CLR:  data_out_d  = data_out_q & ~wdata_c;
                default:   ;
            endcase
        end
    end

    // Interrupt level and read mux, both registered.
    always_comb begin
        irq_d      = |(edgecap_q & irqmask_q);
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA: readdata_d = DW'(sync2_q);
            ADDR_DIR:  readdata_d = DW'(direction_q);
            ADDR_MASK: readdata_d = DW'(irqmask_q);
            ADDR_EDGE: readdata_d = DW'(edgecap_q);
            ADDR_SET:  readdata_d = DW'(data_out_q);
            ADDR_CLR:  readdata_d = DW'(data_out_q);
            default:   readdata_d = '0;
        endcase
    end

    // Architectural state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q  <= RESET_VALUE;
            direction_q <= '0;
            irqmask_q   <= '0;
            edgecap_q   <= '0;
            irq_q       <= 1'b0;
            readdata_q  <= '0;
        end else begin
            data_out_q  <= data_out_d;
            direction_q <= direction_d;
            irqmask_q   <= irqmask_d;
            edgecap_q   <= edgecap_d;
            irq_q       <= irq_d;
            readdata_q  <= readdata_d;
        end
    end

    assign out_port     = data_out_q;
    assign out_en       = direction_q;
    assign irq          = irq_q;
    assign bus.readdata = readdata_q;
endmodule

// File: doc/mysystem_pio_edge.md
MYSYSTEM_PIO_EDGE -- requirements
Module: mysystem_pio_edge

Interface
REQ-001 Parameter WIDTH, default 8, port width in bits; legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0, capture mode: 0 rising, 1 falling, 2 any edge.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit reset value of the output data register.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  3  register select (word address).
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-010 readdata  output  32  registered read data; bits above WIDTH-1 read 0.
REQ-011 in_port  input  WIDTH  external inputs, asynchronous to clk.
REQ-012 out_port  output  WIDTH  output data register.
REQ-013 out_en  output  WIDTH  per-bit output enable (direction register).
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 Register map: 0 data, 1 direction, 2 irqmask, 3 edgecapture, 4 outset, 5 outclear; 6-7 reserved, writes ignored, read 0.
REQ-016 in_port is passed through a 2-flop synchroniser (sync1, sync2), plus a third flop (sync3) for edge detection; all reset to 0.
REQ-017 Edge detect per bit: rising = sync2 & ~sync3; falling = ~sync2 & sync3; any = sync2 ^ sync3; selected by EDGE_TYPE.
REQ-018 Input-to-edgecapture latency: a level change on in_port sets edgecapture 3 clk edges later.
REQ-019 Write addr 0 loads data_out <= writedata[WIDTH-1:0]; out_port = data_out.
REQ-020 Write addr 1 loads direction; out_en = direction (1 = output).
REQ-021 Write addr 2 loads irqmask.
REQ-022 Write addr 3 clears each edgecapture bit where writedata bit = 1; other bits unchanged.
REQ-023 Write addr 4: data_out <= data_out | writedata; write addr 5: data_out <= data_out & ~writedata.
REQ-024 Edgecapture bits are sticky: set by detected edge, cleared only by REQ-022 or reset.
REQ-025 Simultaneous detected edge and write-1-to-clear on the same bit in the same cycle: bit ends set (edge wins).
REQ-026 irq = |(edgecapture & irqmask), registered; asserts one cycle after the edgecapture bit sets, deasserts one cycle after clear or mask.
REQ-027 readdata is updated every cycle (no read strobe) from a mux on address: 0 sync2 (synchronised input), 1 direction, 2 irqmask, 3 edgecapture, 4 data_out, 5 data_out; one-cycle read latency.
REQ-028 Reads have no side effects; edgecapture is not cleared by reading.
REQ-029 Writes with chipselect=0 or write_n=1 have no effect.
REQ-030 Unused upper readdata bits are driven 0 for all WIDTH.

Reset
REQ-031 On reset=1, immediately and independent of clk: data_out=RESET_VALUE, direction=0, irqmask=0, edgecapture=0, sync flops=0, irq=0, readdata=0.
REQ-032 out_port=RESET_VALUE and out_en=0 while reset is asserted.
REQ-033 Reset asserted mid-operation discards pending edges; first edge detection is possible 3 cycles after reset deassertion.
REQ-034 in_port held high through reset release with EDGE_TYPE=0 produces one rising-edge capture once sync flops fill (0-to-1 transition seen); benches account for this.

Verification
REQ-035 WIDTH=8: write 0xA5 to addr 0, then 0x0F to addr 4, then 0x81 to addr 5 -> out_port 0xA5, 0xAF, 0x2E in successive cycles after each write.
REQ-036 EDGE_TYPE=0, irqmask=0x01: in_port[0] 0->1 -> edgecapture=0x01 at 3rd edge, irq=1 one cycle later; write 0x01 to addr 3 -> irq=0 one cycle after.
REQ-037 EDGE_TYPE=2: toggle in_port[3] 1->0 -> edgecapture bit 3 set; EDGE_TYPE=1 same stimulus sets it, EDGE_TYPE=0 does not.
REQ-038 Edge on bit 2 in same cycle as write 0x04 to addr 3 -> edgecapture bit 2 remains 1.
REQ-039 Set direction=0xF0, irqmask=0x3C, edgecapture=0x11 then assert reset mid-cycle -> all outputs return to REQ-031 values without a clk edge.
REQ-040 Read addr 6 and addr 7 after arbitrary writes -> readdata=0x00000000; WIDTH=32 read of addr 0 returns full 32-bit synchronised input.
